// File: rtl/mem_access_ctrl_if.sv
// Bus between the control unit / board and the SRAM access controller.
// master = control unit + board side, slave = mem_access_ctrl.
interface mem_access_ctrl_if;
    logic        Mem_CE;
    logic        Mem_OE;
    logic        Mem_WE;
    logic        Mem_UB;
    logic        Mem_LB;
    logic [15:0] MAR;
    logic [15:0] MDR_Wdata;
    logic [15:0] MDR_Rdata;
    logic        Rd_valid;
    logic        Wr_done;
    logic        Busy;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic [15:0] SRAM_Dout;
    logic        SRAM_Dout_en;
    logic [15:0] SRAM_Din;
    logic [15:0] Switches;
    logic [15:0] HEX_Data;

    modport master (
        output Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, MAR, MDR_Wdata, SRAM_Din, Switches,
        input  MDR_Rdata, Rd_valid, Wr_done, Busy, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
               SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_Dout, SRAM_Dout_en, HEX_Data
    );

    modport slave (
        input  Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, MAR, MDR_Wdata, SRAM_Din, Switches,
        output MDR_Rdata, Rd_valid, Wr_done, Busy, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
               SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_Dout, SRAM_Dout_en, HEX_Data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Async SRAM access sequencer: fixed-timing read/write cycles with registered strobes.
// Define HEX_IO_EN to map address 16'hFFFF onto Switches (read) / HEX_Data (write).
//
// state    | meaning
// IDLE     | waiting for a request, strobes high
// RD1      | CE/OE low, address settling
// RD2      | CE/OE low, data sampled at exit
// RD_DONE  | MDR_Rdata valid, Rd_valid pulse
// WR_SETUP | CE low, data driven, address setup
// WR_PULSE | WE low
// WR_HOLD  | WE high again, data/address held
// WR_DONE  | Wr_done pulse
// WAIT_REL | waiting for the control unit to drop OE/WE
module mem_access_ctrl (
    input  logic             Clk,
    input  logic             Reset,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, RD1, RD2, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, WR_DONE, WAIT_REL
    } state_t;

    state_t      state_q;
    logic [15:0] mdr_q;
    logic [15:0] wdata_q;
    logic [19:0] addr_q;
    logic        io_q;
    logic        rd_valid_q, wr_done_q, busy_q, dout_en_q;
    logic        ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;
    logic        req_wr, req_rd, req_io;
    logic [15:0] rd_src;

    assign req_wr = !bus.Mem_CE && !bus.Mem_WE;
    assign req_rd = !bus.Mem_CE && !bus.Mem_OE && bus.Mem_WE;

`ifdef HEX_IO_EN
    logic [15:0] hex_q;
    assign req_io       = (bus.MAR == 16'hFFFF);
    assign rd_src       = io_q ? bus.Switches : bus.SRAM_Din;
    assign bus.HEX_Data = hex_q;
`else
    logic unused_switches;
    assign req_io          = 1'b0;
    assign rd_src          = bus.SRAM_Din;
    assign bus.HEX_Data    = 16'h0000;
    assign unused_switches = ^bus.Switches;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            mdr_q      <= 16'h0000;
            wdata_q    <= 16'h0000;
            addr_q     <= 20'h0;
            io_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            dout_en_q  <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
`ifdef HEX_IO_EN
            hex_q      <= 16'h0000;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // I/O accesses walk the same states but keep the SRAM deselected
                    if (req_wr || req_rd) begin
                        addr_q  <= {4'h0, bus.MAR};
                        wdata_q <= bus.MDR_Wdata;
                        io_q    <= req_io;
                        busy_q  <= 1'b1;
                        ce_n_q  <= req_io;
                        ub_n_q  <= req_io | bus.Mem_UB;
                        lb_n_q  <= req_io | bus.Mem_LB;
                    end
                    if (req_wr) begin
                        state_q   <= WR_SETUP;
                        dout_en_q <= 1'b1;
                    end else if (req_rd) begin
                        state_q <= RD1;
                        oe_n_q  <= req_io;
                    end
                end
                RD1: state_q <= RD2;
                RD2: begin
                    state_q    <= RD_DONE;
                    mdr_q      <= rd_src;
                    rd_valid_q <= 1'b1;
                    ce_n_q     <= 1'b1;
                    oe_n_q     <= 1'b1;
                    ub_n_q     <= 1'b1;
                    lb_n_q     <= 1'b1;
                end
                RD_DONE: begin
                    state_q    <= WAIT_REL;
                    rd_valid_q <= 1'b0;
                end
                WR_SETUP: begin
                    state_q <= WR_PULSE;
                    we_n_q  <= io_q;
                end
                WR_PULSE: begin
                    state_q <= WR_HOLD;
                    we_n_q  <= 1'b1;
                end
                WR_HOLD: begin
                    state_q   <= WR_DONE;
                    dout_en_q <= 1'b0;
                    wr_done_q <= 1'b1;
`ifdef HEX_IO_EN
                    if (io_q) hex_q <= wdata_q;
`endif
                end
                WR_DONE: begin
                    state_q   <= WAIT_REL;
                    wr_done_q <= 1'b0;
                    ce_n_q    <= 1'b1;
                    ub_n_q    <= 1'b1;
                    lb_n_q    <= 1'b1;
                end
                WAIT_REL: begin
                    if (bus.Mem_OE && bus.Mem_WE) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    rd_valid_q <= 1'b0;
                    wr_done_q  <= 1'b0;
                    dout_en_q  <= 1'b0;
                    ce_n_q     <= 1'b1;
                    oe_n_q     <= 1'b1;
                    we_n_q     <= 1'b1;
                    ub_n_q     <= 1'b1;
                    lb_n_q     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.MDR_Rdata    = mdr_q;
    assign bus.Rd_valid     = rd_valid_q;
    assign bus.Wr_done      = wr_done_q;
    assign bus.Busy         = busy_q;
    assign bus.SRAM_ADDR    = addr_q;
    assign bus.SRAM_Dout    = wdata_q;
    assign bus.SRAM_Dout_en = dout_en_q;
    assign bus.SRAM_CE_N    = ce_n_q;
    assign bus.SRAM_OE_N    = oe_n_q;
    assign bus.SRAM_WE_N    = we_n_q;
    assign bus.SRAM_UB_N    = ub_n_q;
    assign bus.SRAM_LB_N    = lb_n_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table with per-cycle strobe checks,
// scoreboard queues for read data and write strobes, plus reset-in-write sequence.
module tb_mem_access_ctrl;
    logic Clk = 1'b0;
    logic Reset;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

`ifdef HEX_IO_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    typedef struct {
        bit          wr;
        bit          both;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] din;
        bit          ub;
        bit          lb;
        int          hold;
        bit          scr;
        logic [15:0] exp_rd;
    } vec_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
    } wexp_t;

    vec_t        tbl [9];
    logic [15:0] rd_q [$];
    wexp_t       wr_q [$];
    int          checks  = 0;
    int          errors  = 0;
    int          wd_seen = 0;
    int          wd_exp  = 0;
    bit          mon_en  = 1'b0;
    logic [15:0] hex_exp = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event seen, none expected", nm);
    endtask

    task automatic idle_req();
        bus.Mem_CE = 1'b1;
        bus.Mem_OE = 1'b1;
        bus.Mem_WE = 1'b1;
    endtask

    always @(negedge Clk) begin : mon
        wexp_t w;
        if (mon_en && !Reset) begin
            if (bus.Rd_valid === 1'b1) begin
                if (rd_q.size() == 0) fail("rd_unexpected");
                else chk("rd_data", bus.MDR_Rdata, rd_q.pop_front());
            end
            if (bus.SRAM_WE_N === 1'b0) begin
                if (wr_q.size() == 0) fail("we_unexpected");
                else begin
                    w = wr_q.pop_front();
                    chk("we_addr", bus.SRAM_ADDR, w.addr);
                    chk("we_dout", bus.SRAM_Dout, w.data);
                end
            end
            if (bus.Wr_done === 1'b1) wd_seen++;
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        bit          is_w, io;
        int          len, k_idle;
        logic [4:0]  es, em, act_s;
        logic [3:0]  ef, act_f;
        wexp_t       w;
        is_w   = v.wr || v.both;
        io     = HEX && (v.addr == 16'hFFFF);
        len    = is_w ? 4 : 3;
        k_idle = (len + 2 > v.hold + 1) ? len + 2 : v.hold + 1;
        @(negedge Clk);
        #1;
        bus.Mem_CE    = 1'b0;
        bus.Mem_OE    = (v.wr && !v.both) ? 1'b1 : 1'b0;
        bus.Mem_WE    = is_w ? 1'b0 : 1'b1;
        bus.MAR       = v.addr;
        bus.MDR_Wdata = v.wdata;
        bus.Mem_UB    = v.ub;
        bus.Mem_LB    = v.lb;
        bus.SRAM_Din  = v.din;
        if (is_w) begin
            wd_exp++;
            if (io) hex_exp = v.wdata;
            else begin
                w.addr = {4'h0, v.addr};
                w.data = v.wdata;
                wr_q.push_back(w);
            end
        end else begin
            rd_q.push_back(v.exp_rd);
        end
        for (int k = 1; k <= k_idle; k++) begin
            @(negedge Clk);
            em = 5'b11111;
            es = 5'b11111;
            if (k == k_idle) ef = 4'b0000;
            else if (k > len) ef = 4'b1000;
            else if (is_w) begin
                case (k)
                    1, 3: begin es = io ? 5'b11111 : {3'b011, v.ub, v.lb}; ef = 4'b1001; end
                    2:    begin es = io ? 5'b11111 : {3'b010, v.ub, v.lb}; ef = 4'b1001; end
                    default: begin em = 5'b01100; ef = 4'b1010; end
                endcase
            end else begin
                if (k < 3) begin es = io ? 5'b11111 : {3'b001, v.ub, v.lb}; ef = 4'b1000; end
                else begin em = 5'b00100; ef = 4'b1100; end
            end
            act_s = {bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_UB_N, bus.SRAM_LB_N};
            act_f = {bus.Busy, bus.Rd_valid, bus.Wr_done, bus.SRAM_Dout_en};
            chk($sformatf("v%0d k%0d strobes", idx, k), act_s & em, es & em);
            chk($sformatf("v%0d k%0d flags", idx, k), act_f, ef);
            if (k == 1 || k == k_idle) chk($sformatf("v%0d k%0d addr", idx, k), bus.SRAM_ADDR, {4'h0, v.addr});
            if (is_w && k == 2) chk($sformatf("v%0d dout", idx), bus.SRAM_Dout, v.wdata);
            if (!is_w && k == k_idle) chk($sformatf("v%0d mdr_hold", idx), bus.MDR_Rdata, v.exp_rd);
            #1;
            if (k == 1 && v.scr) begin
                bus.MAR       = ~v.addr;
                bus.MDR_Wdata = ~v.wdata;
                bus.Mem_OE    = 1'b0;
                bus.Mem_WE    = 1'b0;
            end
            if (k == v.hold) idle_req();
            if (!is_w && k == 3) bus.SRAM_Din = ~v.din;
        end
        chk($sformatf("v%0d hex", idx), bus.HEX_Data, hex_exp);
    endtask

    initial begin
        Reset         = 1'b1;
        idle_req();
        bus.MAR       = 16'h0000;
        bus.MDR_Wdata = 16'h0000;
        bus.Mem_UB    = 1'b1;
        bus.Mem_LB    = 1'b1;
        bus.SRAM_Din  = 16'h0000;
        bus.Switches  = 16'h0F0F;

        tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 2,  1'b0, 16'hBEEF};
        tbl[1] = '{1'b1, 1'b0, 16'h0020, 16'h1234, 16'h0000, 1'b0, 1'b0, 1,  1'b0, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 10, 1'b0, 16'h5A5A};
        tbl[3] = '{1'b0, 1'b1, 16'h0040, 16'hCAFE, 16'h9999, 1'b0, 1'b0, 2,  1'b0, 16'h0000};
        tbl[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h00A5, 16'h0000, 1'b0, 1'b0, 3,  1'b0, 16'h0000};
        tbl[5] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1357, 1'b0, 1'b0, 2,  1'b0,
                   HEX ? 16'h0F0F : 16'h1357};
        tbl[6] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b1, 1,  1'b1, 16'h0001};
        tbl[7] = '{1'b1, 1'b0, 16'hABCD, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 6,  1'b1, 16'h0000};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1,  1'b0, 16'h0000};

        repeat (2) @(negedge Clk);
        chk("rst_mdr", bus.MDR_Rdata, 16'h0000);
        chk("rst_flags", {bus.Busy, bus.Rd_valid, bus.Wr_done, bus.SRAM_Dout_en}, 4'b0000);
        chk("rst_strobes", {bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_UB_N, bus.SRAM_LB_N}, 5'b11111);
        chk("rst_addr", bus.SRAM_ADDR, 20'h0);
        chk("rst_hex", bus.HEX_Data, 16'h0000);
        #1;
        Reset  = 1'b0;
        mon_en = 1'b1;

        // requests that must not be accepted
        bus.Mem_CE = 1'b1;
        bus.Mem_OE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("no_accept_ce_high", bus.Busy, 1'b0);
        end
        bus.Mem_CE = 1'b0;
        bus.Mem_OE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("no_accept_no_req", bus.Busy, 1'b0);
        end
        idle_req();

        for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

        // reset while WE is low
        @(negedge Clk);
        #1;
        bus.Mem_CE    = 1'b0;
        bus.Mem_WE    = 1'b0;
        bus.MAR       = 16'h0055;
        bus.MDR_Wdata = 16'h7777;
        wr_q.push_back({20'h00055, 16'h7777});
        repeat (2) @(negedge Clk);
        chk("rstwr_we_low", bus.SRAM_WE_N, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        chk("rstwr_we_n", bus.SRAM_WE_N, 1'b1);
        chk("rstwr_dout_en", bus.SRAM_Dout_en, 1'b0);
        chk("rstwr_ce_n", bus.SRAM_CE_N, 1'b1);
        chk("rstwr_busy", bus.Busy, 1'b0);
        chk("rstwr_addr", bus.SRAM_ADDR, 20'h0);
        idle_req();
        @(negedge Clk);
        chk("rstwr_idle", bus.Busy, 1'b0);
        #1;
        Reset = 1'b0;
        begin
            vec_t v;
            v = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'h4242, 1'b0, 1'b0, 1, 1'b0, 16'h4242};
            run_vec(v, 9);
        end

        repeat (2) @(negedge Clk);
        chk("rd_pending", rd_q.size(), 0);
        chk("wr_pending", wr_q.size(), 0);
        chk("wr_done_count", wd_seen, wd_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
